// File: rtl/led_sequencer_if.sv
// Slow-step and LED drive bundle between the divider/config side and the LED sequencer.
interface led_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int PWM_W = 4
);
  logic             tick_src;
  logic [1:0]       mode;
  logic [PWM_W-1:0] brightness;
  logic [WIDTH-1:0] led;
  logic             step;
  logic             dir;

  modport master (
    output tick_src, mode, brightness,
    input  led, step, dir
  );

  modport slave (
    input  tick_src, mode, brightness,
    output led, step, dir
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: syncs a divided-clock bit into clk, steps a pattern
// through one of four modes and applies global PWM brightness.
//
// mode   | meaning
// COUNT  | binary up-count, wraps to 0
// ROTATE | rotate left by one, MSB into bit 0
// BOUNCE | one-hot ping-pong, dir flips at either end without dwell
// HOLD   | pattern frozen, step still pulses
module led_sequencer #(
  parameter int WIDTH = 8,
  parameter int PWM_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  led_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    M_COUNT  = 2'b00,
    M_ROTATE = 2'b01,
    M_BOUNCE = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0] led_q, led_d;

  logic step;
  logic change;
  logic pwm_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      pattern_q <= '0;
      mode_q    <= M_COUNT;
      dir_q     <= 1'b0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      s1_q      <= bus.tick_src;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign step   = s2_q & ~s3_q;
  assign mode_d = mode_e'(bus.mode);
  assign change = (mode_d != mode_q);

  // A mode change reloads the start value and wins over a coincident step.
  always_comb begin
    pattern_d = pattern_q;
    dir_d     = dir_q;
    if (change) begin
      dir_d = 1'b0;
      case (mode_d)
        M_COUNT:  pattern_d = '0;
        M_ROTATE: pattern_d = WIDTH'(1);
        M_BOUNCE: pattern_d = WIDTH'(1);
        default:  pattern_d = pattern_q;
      endcase
    end else if (step) begin
      case (mode_q)
        M_COUNT:  pattern_d = pattern_q + WIDTH'(1);
        M_ROTATE: pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
        M_BOUNCE: begin
          if (!dir_q) begin
            if (pattern_q[WIDTH-1]) begin
              dir_d     = 1'b1;
              pattern_d = pattern_q >> 1;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              dir_d     = 1'b0;
              pattern_d = pattern_q << 1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        default:  pattern_d = pattern_q;
      endcase
    end
  end

  // All-ones brightness forces full on; otherwise duty is brightness/2^PWM_W.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    pwm_on    = (&bus.brightness) ? 1'b1 : (pwm_cnt_q < bus.brightness);
    led_d     = pattern_q & {WIDTH{pwm_on}};
  end

  assign bus.led  = led_q;
  assign bus.step = step;
  assign bus.dir  = dir_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: latency, count wrap, bounce, mode collision, PWM, async reset.
module tb_led_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   step_cnt = 0;
  int   base;
  int   on_cnt;

  led_sequencer_if #(.WIDTH(8), .PWM_W(4)) bus();

  led_sequencer #(.WIDTH(8), .PWM_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.step === 1'b1) step_cnt <= step_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) bus.tick_src = 1'b1;
    repeat (3) @(negedge clk);
    bus.tick_src = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] bounce_exp [0:16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  initial begin
    bus.tick_src   = 1'b0;
    bus.mode       = 2'b00;
    bus.brightness = 4'hF;
    repeat (2) @(negedge clk);
    check("reset_led", 32'(bus.led), 32'h00);
    check("reset_step", 32'(bus.step), 32'h0);
    check("reset_dir", 32'(bus.dir), 32'h0);
    rst_n = 1'b1;

    // Reset/latency: tick held high for 8 clk
    @(negedge clk) bus.tick_src = 1'b1;
    @(negedge clk);
    check("lat_step_n", 32'(bus.step), 32'h0);
    @(negedge clk);
    check("lat_step_n1", 32'(bus.step), 32'h1);
    check("lat_led_n1", 32'(bus.led), 32'h00);
    @(negedge clk);
    check("lat_step_n2", 32'(bus.step), 32'h0);
    check("lat_led_n2", 32'(bus.led), 32'h00);
    @(negedge clk);
    check("lat_led_n3", 32'(bus.led), 32'h01);
    repeat (5) @(negedge clk);
    check("lat_single_step", 32'(step_cnt), 32'd1);
    bus.tick_src = 1'b0;
    repeat (4) @(negedge clk);

    // COUNT wrap
    repeat (254) tick();
    check("cnt_ff", 32'(bus.led), 32'hFF);
    check("cnt_steps_255", 32'(step_cnt), 32'd255);
    tick();
    check("cnt_wrap", 32'(bus.led), 32'h00);
    check("cnt_steps_256", 32'(step_cnt), 32'd256);

    // BOUNCE
    @(negedge clk) bus.mode = 2'b10;
    repeat (3) @(negedge clk);
    check("bnc_start", 32'(bus.led), 32'h01);
    check("bnc_start_dir", 32'(bus.dir), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("bnc_led_%0d", i), 32'(bus.led), 32'(bounce_exp[i]));
      check($sformatf("bnc_dir_%0d", i), 32'(bus.dir), (i >= 8 && i <= 14) ? 32'h1 : 32'h0);
    end

    // Mode change collision: ROTATE at 08, switch to BOUNCE while step is high
    @(negedge clk) bus.mode = 2'b01;
    repeat (3) @(negedge clk);
    check("rot_start", 32'(bus.led), 32'h01);
    repeat (3) tick();
    check("rot_08", 32'(bus.led), 32'h08);
    @(negedge clk) bus.tick_src = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("col_step_high", 32'(bus.step), 32'h1);
    bus.mode = 2'b10;
    @(negedge clk) bus.tick_src = 1'b0;
    repeat (4) @(negedge clk);
    check("col_led", 32'(bus.led), 32'h01);
    check("col_dir", 32'(bus.dir), 32'h0);
    @(negedge clk) bus.mode = 2'b11;
    base = step_cnt;
    repeat (3) tick();
    check("hold_led", 32'(bus.led), 32'h01);
    check("hold_steps", 32'(step_cnt - base), 32'd3);

    // PWM: reach FF in COUNT, then HOLD
    @(negedge clk) bus.mode = 2'b00;
    repeat (3) @(negedge clk);
    check("pwm_cnt_zero", 32'(bus.led), 32'h00);
    repeat (255) tick();
    @(negedge clk) bus.mode = 2'b11;
    repeat (3) @(negedge clk);
    check("pwm_ff", 32'(bus.led), 32'hFF);

    bus.brightness = 4'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("pwm_b0_%0d", i), 32'(bus.led), 32'h00);
      @(negedge clk);
    end

    bus.brightness = 4'h4;
    repeat (2) @(negedge clk);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.led === 8'hFF) on_cnt++;
      check($sformatf("pwm_b4_val_%0d", i), 32'((bus.led === 8'hFF) || (bus.led === 8'h00)), 32'h1);
      @(negedge clk);
    end
    check("pwm_b4_on_cnt", 32'(on_cnt), 32'd4);

    bus.brightness = 4'hF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("pwm_bf_%0d", i), 32'(bus.led), 32'hFF);
      @(negedge clk);
    end

    // Async reset mid-BOUNCE while step is high and dir=1
    @(negedge clk) bus.mode = 2'b10;
    repeat (3) @(negedge clk);
    repeat (8) tick();
    check("ar_pre_led", 32'(bus.led), 32'h40);
    check("ar_pre_dir", 32'(bus.dir), 32'h1);
    @(negedge clk) bus.tick_src = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ar_pre_step", 32'(bus.step), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_led", 32'(bus.led), 32'h00);
    check("ar_dir", 32'(bus.dir), 32'h0);
    check("ar_step", 32'(bus.step), 32'h0);
    bus.tick_src = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_post_led", 32'(bus.led), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
